// File: rtl/mem_access_arbiter.sv
// -----------------------------------------------------------------------------
// mem_access_arbiter
//
// Purpose:
//   Shares one single-ported memory between the instruction-fetch port and the
//   memory-stage (data) port. A three-state FSM (IDLE -> ACCESS -> DONE) grants
//   one requester and latches its command. It then either drives the memory
//   until mem_ready or a wait timeout, or, for an out-of-range address, skips
//   the memory and reports an error. It then returns a one-cycle ack to the
//   owner. Data wins contended grants. The optional starvation guard
//   periodically hands a contended grant to fetch.
//
// Configuration:
//   MEM_ARB_STARVE_GUARD_EN  when defined, compiles in the fetch starvation
//                            guard (loss counter compared against STARVE_LIMIT).
//                            When undefined, data priority is strict.
//
// Parameters:
//   MEM_BYTES     size of the unified memory; an address is legal iff < MEM_BYTES
//   TIMEOUT       ACCESS cycles to wait for mem_ready before aborting (1..15)
//   STARVE_LIMIT  consecutive contended fetch losses tolerated by the guard
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   if_req, if_addr                fetch read request / byte address
//   if_ack, if_rdata, if_err       fetch completion pulse, read data, error
//   dm_req, dm_we, dm_addr,        data request, write enable, byte address,
//   dm_wdata                       write data
//   dm_ack, dm_rdata, dm_err       data completion pulse, read data, error
//   mem_en, mem_we, mem_addr,      memory strobe, write enable, address,
//   mem_wdata                      write data (all registered)
//   mem_rdata, mem_ready           memory read data, completion
//
// State table:
//   state     | meaning
//   ST_IDLE   | sample requests, arbitrate, latch the winner's command
//   ST_ACCESS | memory strobe active, waiting for mem_ready or timeout
//   ST_DONE   | one-cycle ack to the owner with registered rdata/err
// -----------------------------------------------------------------------------
module mem_access_arbiter #(
  parameter int MEM_BYTES    = 1024,
  parameter int TIMEOUT      = 15,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_ack,
  output logic [63:0] if_rdata,
  output logic        if_err,

  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [63:0] dm_addr,
  input  logic [63:0] dm_wdata,
  output logic        dm_ack,
  output logic [63:0] dm_rdata,
  output logic        dm_err,

  output logic        mem_en,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);

  // The wait counter is 4 bits wide, so the timeout must fit in it.
  if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_timeout
    $error("mem_access_arbiter: TIMEOUT must be in 1..15");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
    $error("mem_access_arbiter: STARVE_LIMIT must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  // Latched command of the current owner (owner_data: 1 = data, 0 = fetch)
  logic        owner_data;
  logic        we_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [3:0]  wait_cnt;

  logic        grant;
  logic        grant_data;
  logic        grant_legal;
  logic [63:0] sel_addr;
  logic        starve_force;
  logic        wait_hit;
  logic        fin_err;
  logic [63:0] fin_rdata;

  logic        nx_owner;
  logic        nx_we;
  logic [63:0] nx_addr;
  logic [63:0] nx_wdata;
  logic        access_next;
  logic        done_next;

  // Arbitration: data wins unless the guard forces a contended grant to fetch.
  assign grant_data  = dm_req && !(if_req && starve_force);
  assign sel_addr    = grant_data ? dm_addr : if_addr;
  assign grant_legal = (sel_addr < MEM_LIMIT);

  // The counter increments this cycle (no mem_ready); the access times out
  // once that increment makes it equal to TIMEOUT.
  assign wait_hit = (({1'b0, wait_cnt} + 5'd1) == 5'(TIMEOUT));

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    fin_err    = 1'b0;
    fin_rdata  = '0;
    case (state)
      ST_IDLE: begin
        if (if_req || dm_req) begin
          grant      = 1'b1;
          state_next = grant_legal ? ST_ACCESS : ST_DONE;
          fin_err    = !grant_legal;
        end
      end
      ST_ACCESS: begin
        if (mem_ready) begin
          // mem_ready beats a timeout landing in the same cycle
          state_next = ST_DONE;
          fin_rdata  = we_q ? '0 : mem_rdata;
        end else if (wait_hit) begin
          state_next = ST_DONE;
          fin_err    = 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Command that will be in force next cycle: fresh grant values on the
  // IDLE->ACCESS edge, latched values while the access continues.
  assign nx_owner    = grant ? grant_data : owner_data;
  assign nx_we       = grant ? (grant_data & dm_we) : we_q;
  assign nx_addr     = grant ? sel_addr : addr_q;
  assign nx_wdata    = grant ? (grant_data ? dm_wdata : 64'd0) : wdata_q;
  assign access_next = (state_next == ST_ACCESS);
  assign done_next   = (state_next == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner_data <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wait_cnt   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ack     <= 1'b0;
      if_rdata   <= '0;
      if_err     <= 1'b0;
      dm_ack     <= 1'b0;
      dm_rdata   <= '0;
      dm_err     <= 1'b0;
    end else begin
      state <= state_next;

      if (grant) begin
        owner_data <= grant_data;
        we_q       <= grant_data & dm_we;
        addr_q     <= sel_addr;
        wdata_q    <= grant_data ? dm_wdata : 64'd0;
      end

      // Held at zero outside ACCESS, so every access starts from zero.
      if (state != ST_ACCESS) begin
        wait_cnt <= '0;
      end else if (!mem_ready) begin
        wait_cnt <= wait_cnt + 4'd1;
      end

      // Memory side is zero whenever no access is in flight.
      mem_en    <= access_next;
      mem_we    <= access_next & nx_we;
      mem_addr  <= access_next ? nx_addr : 64'd0;
      mem_wdata <= access_next ? nx_wdata : 64'd0;

      // Responses exist only during DONE and only for the owner.
      if_ack   <= done_next & !nx_owner;
      if_err   <= done_next & !nx_owner & fin_err;
      if_rdata <= (done_next && !nx_owner) ? fin_rdata : 64'd0;
      dm_ack   <= done_next & nx_owner;
      dm_err   <= done_next & nx_owner & fin_err;
      dm_rdata <= (done_next && nx_owner) ? fin_rdata : 64'd0;
    end
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int LOSS_W = $clog2(STARVE_LIMIT + 1);

  // Counts data grants made while fetch was also waiting. It cannot pass
  // STARVE_LIMIT because a contended grant at the limit goes to fetch.
  logic [LOSS_W-1:0] loss_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loss_cnt <= '0;
    end else if (grant) begin
      if (!grant_data) begin
        loss_cnt <= '0;
      end else if (if_req) begin
        loss_cnt <= loss_cnt + 1'b1;
      end
    end
  end

  assign starve_force = (loss_cnt == LOSS_W'(STARVE_LIMIT));
`else
  assign starve_force = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_arbiter.sv
module tb_mem_access_arbiter;

  localparam int MEM_BYTES    = 1024;
  localparam int TIMEOUT      = 15;
  localparam int STARVE_LIMIT = 4;
  localparam int NEVER        = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_ack;
  logic [63:0] if_rdata;
  logic        if_err;
  logic        dm_req;
  logic        dm_we;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic        dm_ack;
  logic [63:0] dm_rdata;
  logic        dm_err;
  logic        mem_en;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ready;

  always #5 clk = ~clk;

  mem_access_arbiter #(
    .MEM_BYTES(MEM_BYTES), .TIMEOUT(TIMEOUT), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // cycle counter since last clear_log, memory responder config and logs
  int          cyc        = 0;
  int          mem_lat    = 0;
  bit          rd_ovr_en  = 1'b0;
  logic [63:0] rd_ovr     = '0;
  int          mem_cnt    = 0;
  int          acc_cycles = 0;
  bit          hold_reqs  = 1'b0;
  int          viol_both  = 0;
  int          viol_idle  = 0;

  bit          q_own[$];
  logic [63:0] q_data[$];
  bit          q_err[$];
  int          q_cyc[$];
  bit          a_we[$];
  logic [63:0] a_addr[$];
  logic [63:0] a_wdata[$];

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_C3C3, ~a[31:0]};
  endfunction

  function automatic bit outs_zero();
    return !(if_ack || if_err || dm_ack || dm_err || mem_en || mem_we ||
             (if_rdata != 0) || (dm_rdata != 0) || (mem_addr != 0) || (mem_wdata != 0));
  endfunction

  // One clock: sample at negedge, log acks, act as requesters and as memory.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (if_ack && dm_ack) viol_both++;
    if (!if_ack && (if_rdata != 0 || if_err)) viol_idle++;
    if (!dm_ack && (dm_rdata != 0 || dm_err)) viol_idle++;
    if (if_ack) begin
      q_own.push_back(1'b0); q_data.push_back(if_rdata); q_err.push_back(if_err); q_cyc.push_back(cyc);
      if (!hold_reqs) if_req = 1'b0;
    end
    if (dm_ack) begin
      q_own.push_back(1'b1); q_data.push_back(dm_rdata); q_err.push_back(dm_err); q_cyc.push_back(cyc);
      if (!hold_reqs) dm_req = 1'b0;
    end
    if (mem_en) begin
      acc_cycles++;
      if (mem_cnt == mem_lat) begin
        mem_ready = 1'b1;
        mem_rdata = rd_ovr_en ? rd_ovr : mem_word(mem_addr);
        a_we.push_back(mem_we); a_addr.push_back(mem_addr); a_wdata.push_back(mem_wdata);
      end else begin
        mem_ready = 1'b0;
        mem_rdata = {$urandom, $urandom};
      end
      mem_cnt++;
    end else begin
      mem_ready = 1'b0;
      mem_rdata = {$urandom, $urandom};
      mem_cnt   = 0;
    end
  endtask

  task automatic clear_log();
    q_own.delete(); q_data.delete(); q_err.delete(); q_cyc.delete();
    a_we.delete(); a_addr.delete(); a_wdata.delete();
    acc_cycles = 0;
    cyc        = 0;
  endtask

  task automatic run_idle(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (!if_req && !dm_req) begin
        timed_out = 1'b0;
        break;
      end
      step();
    end
    step();
  endtask

  task automatic test_reset();
    if_req = 0; dm_req = 0; dm_we = 0; if_addr = 0; dm_addr = 0; dm_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
    rst = 1'b1;
    #1;
    n_tests++;
    if (outs_zero() !== 1'b1) begin
      n_fail++; $display("FAIL reset_assert: outputs not zero (if_ack=%0b dm_ack=%0b mem_en=%0b), expected all 0", if_ack, dm_ack, mem_en);
    end
    repeat (2) step();
    rst = 1'b0;
    repeat (2) step();
    n_tests++;
    if (outs_zero() !== 1'b1) begin
      n_fail++; $display("FAIL reset_release: outputs not zero (if_ack=%0b dm_ack=%0b mem_en=%0b), expected all 0", if_ack, dm_ack, mem_en);
    end
  endtask

  task automatic test_fetch_read();
    bit to;
    clear_log();
    mem_lat = 1; rd_ovr_en = 1'b1; rd_ovr = 64'h1122_3344_5566_7788;
    if_addr = 64'h10; if_req = 1'b1;
    run_idle(60, to);
    rd_ovr_en = 1'b0;
    n_tests++;
    if (to || q_own.size() != 1 || q_own[0] != 1'b0) begin
      n_fail++; $display("FAIL fetch_ack: timeout=%0b acks=%0d, expected one fetch ack", to, q_own.size());
    end else begin
      n_tests++;
      if (q_data[0] !== 64'h1122_3344_5566_7788 || q_err[0] !== 1'b0) begin
        n_fail++; $display("FAIL fetch_data: got %h err %0b, expected 1122334455667788 err 0", q_data[0], q_err[0]);
      end
      n_tests++;
      if (q_cyc[0] != 3) begin
        n_fail++; $display("FAIL fetch_latency: ack at cycle %0d, expected 3", q_cyc[0]);
      end
    end
    n_tests++;
    if (a_we.size() != 1 || a_we[0] !== 1'b0 || a_addr[0] !== 64'h10 || acc_cycles != 2) begin
      n_fail++; $display("FAIL fetch_mem: accesses=%0d we=%0b addr=%h en_cycles=%0d, expected 1 read of 0x10 over 2 cycles",
                         a_we.size(), a_we.size() ? a_we[0] : 1'b0, a_addr.size() ? a_addr[0] : 64'h0, acc_cycles);
    end
  endtask

  task automatic test_contention();
    bit to;
    clear_log();
    mem_lat = 0;
    if_addr = 64'h40; dm_addr = 64'h20; dm_we = 1'b1; dm_wdata = 64'hAB;
    if_req = 1'b1; dm_req = 1'b1;
    run_idle(60, to);
    dm_we = 1'b0;
    n_tests++;
    if (to || q_own.size() != 2 || q_own[0] != 1'b1 || q_own[1] != 1'b0) begin
      n_fail++; $display("FAIL contention_order: timeout=%0b acks=%0d, expected data then fetch", to, q_own.size());
    end else begin
      n_tests++;
      if (q_data[0] !== 64'h0 || q_err[0] !== 1'b0 || q_cyc[0] != 2 ||
          q_data[1] !== mem_word(64'h40) || q_err[1] !== 1'b0 || q_cyc[1] != 5) begin
        n_fail++; $display("FAIL contention_resp: dm %h/%0b@%0d if %h/%0b@%0d, expected 0/0@2 %h/0@5",
                           q_data[0], q_err[0], q_cyc[0], q_data[1], q_err[1], q_cyc[1], mem_word(64'h40));
      end
    end
    n_tests++;
    if (a_we.size() != 2 || a_we[0] !== 1'b1 || a_addr[0] !== 64'h20 || a_wdata[0] !== 64'hAB ||
        a_we[1] !== 1'b0 || a_addr[1] !== 64'h40) begin
      n_fail++; $display("FAIL contention_mem: %0d accesses, expected write 0xAB@0x20 then read 0x40", a_we.size());
    end
  endtask

  task automatic test_illegal();
    bit to;
    clear_log();
    mem_lat = 0;
    dm_addr = 64'(MEM_BYTES); dm_we = 1'b0; dm_req = 1'b1;
    run_idle(60, to);
    n_tests++;
    if (to || q_own.size() != 1 || q_own[0] != 1'b1 || q_err[0] !== 1'b1 || q_data[0] !== 64'h0 ||
        q_cyc[0] != 1 || acc_cycles != 0) begin
      n_fail++; $display("FAIL illegal_1024: acks=%0d err=%0b cyc=%0d en_cycles=%0d, expected err ack at 1 with no mem_en",
                         q_own.size(), q_err.size() ? q_err[0] : 1'b0, q_cyc.size() ? q_cyc[0] : -1, acc_cycles);
    end
    clear_log();
    dm_addr = 64'(MEM_BYTES - 1); dm_we = 1'b1; dm_wdata = 64'h55; dm_req = 1'b1;
    run_idle(60, to);
    dm_we = 1'b0;
    n_tests++;
    if (to || q_own.size() != 1 || q_err[0] !== 1'b0 || q_cyc[0] != 2 || acc_cycles != 1) begin
      n_fail++; $display("FAIL legal_1023: acks=%0d err=%0b cyc=%0d en_cycles=%0d, expected ok ack at 2 with 1 mem cycle",
                         q_own.size(), q_err.size() ? q_err[0] : 1'b0, q_cyc.size() ? q_cyc[0] : -1, acc_cycles);
    end
    clear_log();
    if_addr = 64'hFFFF_FFFF_FFFF_FFF0; if_req = 1'b1;
    run_idle(60, to);
    n_tests++;
    if (to || q_own.size() != 1 || q_own[0] != 1'b0 || q_err[0] !== 1'b1 || acc_cycles != 0) begin
      n_fail++; $display("FAIL illegal_fetch: acks=%0d en_cycles=%0d, expected one fetch err ack, no mem_en", q_own.size(), acc_cycles);
    end
  endtask

  task automatic test_timeout();
    bit to;
    int lats[3] = '{NEVER, TIMEOUT - 1, TIMEOUT - 2};
    for (int k = 0; k < 3; k++) begin
      bit          e_err;
      int          e_cyc;
      logic [63:0] e_data;
      clear_log();
      mem_lat = lats[k];
      dm_addr = 64'h100; dm_we = 1'b0; dm_req = 1'b1;
      run_idle(80, to);
      e_err  = (lats[k] >= TIMEOUT);
      e_cyc  = e_err ? TIMEOUT + 1 : lats[k] + 2;
      e_data = e_err ? 64'h0 : mem_word(64'h100);
      n_tests++;
      if (to || q_own.size() != 1 || q_err[0] !== e_err || q_data[0] !== e_data || q_cyc[0] != e_cyc ||
          acc_cycles != (e_err ? TIMEOUT : lats[k] + 1)) begin
        n_fail++; $display("FAIL timeout_lat%0d: acks=%0d err=%0b cyc=%0d en_cycles=%0d, expected err=%0b cyc=%0d",
                           lats[k], q_own.size(), q_err.size() ? q_err[0] : 1'b0, q_cyc.size() ? q_cyc[0] : -1,
                           acc_cycles, e_err, e_cyc);
      end
    end
    // back in IDLE: a fresh request is served with minimum latency
    clear_log();
    mem_lat = 0; dm_req = 1'b1;
    run_idle(60, to);
    n_tests++;
    if (to || q_cyc.size() != 1 || q_cyc[0] != 2) begin
      n_fail++; $display("FAIL timeout_idle: acks=%0d, expected one ack at cycle 2", q_cyc.size());
    end
  endtask

  task automatic test_reset_mid_access();
    clear_log();
    mem_lat = NEVER;
    dm_addr = 64'h80; dm_we = 1'b1; dm_wdata = 64'hDEAD; dm_req = 1'b1;
    repeat (4) step();
    n_tests++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1) begin
      n_fail++; $display("FAIL midreset_pre: mem_en=%0b mem_we=%0b, expected 1/1", mem_en, mem_we);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (outs_zero() !== 1'b1) begin
      n_fail++; $display("FAIL midreset_zero: mem_en=%0b mem_addr=%h, expected all outputs 0", mem_en, mem_addr);
    end
    dm_req = 1'b0; dm_we = 1'b0;
    step();
    rst = 1'b0;
    clear_log();
    mem_lat = 0;
    repeat (20) step();
    n_tests++;
    if (q_own.size() != 0 || acc_cycles != 0) begin
      n_fail++; $display("FAIL midreset_noack: acks=%0d en_cycles=%0d, expected 0/0", q_own.size(), acc_cycles);
    end
  endtask

  function automatic logic [63:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 64'(MEM_BYTES) + 64'($urandom_range(0, 4096));
      1:       return {1'b1, 31'($urandom), $urandom};
      default: return 64'($urandom_range(0, MEM_BYTES - 1));
    endcase
  endfunction

  task automatic test_random();
    int loss_m = 0;
    for (int it = 0; it < 40; it++) begin
      int          kind;
      int          lat;
      int          v;
      int          t0;
      int          exp_acc;
      bit          to;
      bit          e_own[$];
      bit          e_err[$];
      logic [63:0] e_data[$];
      int          e_cyc[$];
      bit          x_we[$];
      logic [63:0] x_addr[$];
      logic [63:0] x_wdata[$];
      logic [63:0] fa;
      logic [63:0] da;
      logic [63:0] dwd;
      bit          dwe;
      bit          both;
      bit          data_first;

      clear_log();
      kind = $urandom_range(1, 3);
      fa   = pick_addr();
      da   = pick_addr();
      dwe  = 1'($urandom_range(0, 1));
      dwd  = {$urandom, $urandom};
      v    = $urandom_range(0, 6);
      lat  = (v == 6) ? NEVER : v;

      // grant order from the priority rules
      both = (kind == 3);
      data_first = (kind != 1);
`ifdef MEM_ARB_STARVE_GUARD_EN
      if (both && loss_m == STARVE_LIMIT) data_first = 1'b0;
`endif
      if (kind == 1) e_own.push_back(1'b0);
      else if (kind == 2) e_own.push_back(1'b1);
      else if (data_first) begin e_own.push_back(1'b1); e_own.push_back(1'b0); end
      else begin e_own.push_back(1'b0); e_own.push_back(1'b1); end

      t0 = 0;
      exp_acc = 0;
      for (int g = 0; g < e_own.size(); g++) begin
        logic [63:0] a;
        bit          we;
        bit          legal;
        bit          err;
        int          l;
        a     = e_own[g] ? da : fa;
        we    = e_own[g] ? dwe : 1'b0;
        legal = (a < 64'(MEM_BYTES));
        err   = !legal || (lat >= TIMEOUT);
        l     = !legal ? 1 : ((lat >= TIMEOUT) ? TIMEOUT + 1 : lat + 2);
        e_err.push_back(err);
        e_data.push_back((err || we) ? 64'h0 : mem_word(a));
        e_cyc.push_back(t0 + l);
        t0 = t0 + l + 1;
        if (legal) exp_acc += (lat >= TIMEOUT) ? TIMEOUT : lat + 1;
        if (legal && lat < TIMEOUT) begin
          x_we.push_back(we); x_addr.push_back(a); x_wdata.push_back(we ? dwd : 64'h0);
        end
        // contended data grant costs fetch a loss; any fetch grant resets it
        if (!e_own[g]) loss_m = 0;
        else if (both && g == 0) loss_m++;
      end

      mem_lat = lat;
      if_addr = fa; dm_addr = da; dm_we = dwe; dm_wdata = dwd;
      if_req = kind[0]; dm_req = kind[1];
      run_idle(100, to);

      n_tests++;
      if (to || q_own.size() != e_own.size()) begin
        n_fail++; $display("FAIL rand%0d_count: timeout=%0b acks=%0d, expected %0d", it, to, q_own.size(), e_own.size());
      end else begin
        for (int g = 0; g < e_own.size(); g++) begin
          n_tests++;
          if (q_own[g] !== e_own[g] || q_err[g] !== e_err[g] || q_data[g] !== e_data[g] || q_cyc[g] != e_cyc[g]) begin
            n_fail++; $display("FAIL rand%0d_ack%0d: own=%0b err=%0b data=%h cyc=%0d, expected own=%0b err=%0b data=%h cyc=%0d",
                               it, g, q_own[g], q_err[g], q_data[g], q_cyc[g], e_own[g], e_err[g], e_data[g], e_cyc[g]);
          end
        end
      end
      n_tests++;
      if (acc_cycles != exp_acc || a_we.size() != x_we.size()) begin
        n_fail++; $display("FAIL rand%0d_mem: en_cycles=%0d accesses=%0d, expected %0d/%0d",
                           it, acc_cycles, a_we.size(), exp_acc, x_we.size());
      end else begin
        for (int g = 0; g < x_we.size(); g++) begin
          n_tests++;
          if (a_we[g] !== x_we[g] || a_addr[g] !== x_addr[g] || (x_we[g] && a_wdata[g] !== x_wdata[g])) begin
            n_fail++; $display("FAIL rand%0d_acc%0d: we=%0b addr=%h wdata=%h, expected we=%0b addr=%h wdata=%h",
                               it, g, a_we[g], a_addr[g], a_wdata[g], x_we[g], x_addr[g], x_wdata[g]);
          end
        end
      end
      dm_we = 1'b0;
    end
    n_tests++;
    if (viol_both != 0 || viol_idle != 0) begin
      n_fail++; $display("FAIL ack_rules: both-ack cycles=%0d nonzero idle resp=%0d, expected 0/0", viol_both, viol_idle);
    end
  endtask

  task automatic test_starvation();
    int n;
    int loss_m = 0;
    int n_fetch = 0;
    bit to;
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_log();
    mem_lat = 0; hold_reqs = 1'b1;
    if_addr = 64'h8; dm_addr = 64'h18; dm_we = 1'b0;
    if_req = 1'b1; dm_req = 1'b1;
    repeat (60) step();
    n = q_own.size();
    hold_reqs = 1'b0;
    run_idle(60, to);
    n_tests++;
    if (n != 20) begin
      n_fail++; $display("FAIL starve_count: %0d acks in 60 cycles, expected 20", n);
    end
    for (int i = 0; i < n; i++) begin
      bit e;
      e = 1'b1;
`ifdef MEM_ARB_STARVE_GUARD_EN
      if (loss_m == STARVE_LIMIT) e = 1'b0;
`endif
      if (e) loss_m++; else loss_m = 0;
      if (!q_own[i]) n_fetch++;
      n_tests++;
      if (q_own[i] !== e) begin
        n_fail++; $display("FAIL starve_grant%0d: owner=%0b, expected %0b", i, q_own[i], e);
      end
    end
    n_tests++;
    if (to) begin
      n_fail++; $display("FAIL starve_drain: requests still pending after budget, expected idle");
    end
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_contention();
    test_illegal();
    test_timeout();
    test_reset_mid_access();
    test_random();
    test_starvation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
